// File: rtl/mem_seq_pkg.sv
// Size codes, sequencer states and size decode shared by the load/store
// sequencer and the control unit's load/store decode.
package mem_seq_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRAIN,
        RESP
    } seq_state_e;

    // The illegal code 11 maps to 4; such requests never reach the access phase.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_read_assembler.sv
// Big-endian load assembly: each captured byte shifts in at the bottom of a
// 32-bit accumulator that is cleared when a new request is accepted.
module mem_read_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] acc_next_o
);

    logic [31:0] acc_q;
    logic [31:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (shift_en_i) begin
            acc_d = (acc_q << 8) | {24'h000000, byte_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Exposes the value including the byte landing this cycle so the final
    // byte can be folded into the response register without an extra cycle.
    assign acc_next_o = acc_d;

endmodule

// File: rtl/mem_access_sequencer.sv
// Load/store initiator: turns one aligned request into 1, 2 or 4 big-endian
// byte accesses on the byte-wide memory port and returns a one-cycle response.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata
);

    seq_state_e        state_q, state_d;
    logic              ready_q, ready_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              rd_pend_q;

    logic              accept;
    logic              req_err;
    logic              last_byte;
    logic [1:0]        cnt_next;
    logic [31:0]       acc_next;

    // Byte k of an N-byte store is the (N-1-k)th byte lane of the right-aligned data.
    function automatic logic [7:0] store_byte(input logic [31:0] w, input logic [2:0] n,
                                              input logic [1:0] k);
        logic [1:0] lane;
        lane = 2'(n - 3'd1 - {1'b0, k});
        return w[{lane, 3'b000} +: 8];
    endfunction

    assign accept    = (state_q == IDLE) && req_valid;
    assign req_err   = (req_size == 2'b11)
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign last_byte = ({1'b0, cnt_q} == (nbytes_q - 3'd1));
    assign cnt_next  = cnt_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        mem_en_d    = 1'b0;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        write_d     = write_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        nbytes_d    = nbytes_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    base_d   = req_addr;
                    wdata_d  = req_wdata;
                    nbytes_d = size_to_bytes(req_size);
                    cnt_d    = 2'd0;
                    ready_d  = 1'b0;
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_en_d    = 1'b1;
                        mem_rw_d    = req_write;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = store_byte(req_wdata, size_to_bytes(req_size), 2'd0);
                    end
                end
            end
            ACCESS: begin
                if (last_byte) begin
                    // Loads need one more cycle for the last read byte to arrive.
                    if (write_q) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    cnt_d       = cnt_next;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = base_q + ADDR_W'(cnt_next);
                    mem_wdata_d = store_byte(wdata_q, nbytes_q, cnt_next);
                end
            end
            DRAIN: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = acc_next;
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            write_q     <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            nbytes_q    <= 3'd1;
            cnt_q       <= 2'd0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            write_q     <= write_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            nbytes_q    <= nbytes_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= mem_en_q & ~mem_rw_q;
        end
    end

    mem_read_assembler u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (accept),
        .shift_en_i (rd_pend_q),
        .byte_i     (mem_rdata),
        .acc_next_o (acc_next)
    );

    assign req_ready = ready_q;
    assign mem_en    = mem_en_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: byte-wide memory model, expected access and
// response queues filled as requests are driven, and per-scenario tasks.
module tb_mem_access_sequencer;
    import mem_seq_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size  = 2'b00;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [31:0]       req_wdata = '0;
    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;

    typedef struct {
        int                cyc;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } acc_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        logic              wr;
        logic [1:0]        sz;
        logic [ADDR_W-1:0] ad;
        logic [31:0]       wd;
    } req_t;

    acc_t        expAcc[$];
    acc_t        obsAcc[$];
    rsp_t        expRsp[$];
    rsp_t        obsRsp[$];
    logic [7:0]  memArray [256] = '{default: 8'h00};
    logic [7:0]  refMem [256]   = '{default: 8'h00};
    logic [31:0] lastRdata      = 32'h0;
    int          cyc            = 0;
    int          compared       = 0;
    int          mismatched     = 0;

    mem_access_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    // Byte-wide memory: writes land at the edge, read data is valid the next cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en && mem_rw) memArray[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_rw) mem_rdata <= memArray[mem_addr[7:0]];
    end

    // Records every byte access and response with the cycle it was seen in.
    always @(negedge clk) begin
        acc_t a;
        rsp_t r;
        if (mem_en) begin
            a.cyc = cyc; a.rw = mem_rw; a.addr = mem_addr; a.data = mem_wdata;
            obsAcc.push_back(a);
        end
        if (rsp_valid) begin
            r.cyc = cyc; r.err = rsp_err; r.rdata = rsp_rdata;
            obsRsp.push_back(r);
        end
    end

    // Expected behaviour of one request accepted at the edge ending cycle 'base'.
    function automatic void predict(input logic wr, input logic [1:0] sz,
                                    input logic [ADDR_W-1:0] ad, input logic [31:0] wd,
                                    input int base);
        int                n;
        logic [31:0]       word;
        logic [ADDR_W-1:0] a;
        acc_t              e;
        rsp_t              r;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        word = 32'h0;
        r.err = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
        if (!r.err) begin
            for (int k = 0; k < n; k++) begin
                a      = ad + ADDR_W'(k);
                e.cyc  = base + 1 + k;
                e.rw   = wr;
                e.addr = a;
                e.data = wr ? wd[8*(n-1-k) +: 8] : 8'h00;
                expAcc.push_back(e);
                if (wr) refMem[a[7:0]] = e.data;
                else    word = (word << 8) | {24'h0, refMem[a[7:0]]};
            end
            if (!wr) lastRdata = word;
        end
        r.cyc   = r.err ? base + 1 : (wr ? base + n + 1 : base + n + 2);
        r.rdata = lastRdata;
        expRsp.push_back(r);
    endfunction

    // Called at a negedge while idle; returns at the negedge of cycle 1.
    task automatic issue(input logic wr, input logic [1:0] sz,
                         input logic [ADDR_W-1:0] ad, input logic [31:0] wd);
        int base;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = ad; req_wdata = wd;
        @(negedge clk);
        base      = cyc - 1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_size  = 2'($urandom);
        req_addr  = ADDR_W'($urandom);
        req_wdata = $urandom;
        predict(wr, sz, ad, wd, base);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (req_ready !== 1'b1 || mem_en !== 1'b0 || mem_rw !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got ready %b en %b rw %b, want 1 0 0", req_ready, mem_en, mem_rw);
        end
        compared++;
        if (mem_addr !== '0 || mem_wdata !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_mem: got addr %h wdata %h, want 0 0", mem_addr, mem_wdata);
        end
        compared++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_rsp: got valid %b err %b rdata %h, want 0 0 0", rsp_valid, rsp_err, rsp_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b1 || mem_en !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_release: got ready %b en %b, want 1 0", req_ready, mem_en);
        end
    endtask

    task automatic test_store_load();
        req_t reqs [10];
        acc_t e, o;
        rsp_t er, orr;
        reqs = '{
            '{1'b1, SZ_WORD, 32'h0000_0010, 32'hDEADBEEF},
            '{1'b0, SZ_WORD, 32'h0000_0010, 32'h0},
            '{1'b0, SZ_HALF, 32'h0000_0012, 32'h0},
            '{1'b0, SZ_BYTE, 32'h0000_0011, 32'h0},
            '{1'b1, SZ_HALF, 32'h0000_0020, 32'h1234ABCD},
            '{1'b1, SZ_WORD, 32'hFFFF_FFFC, 32'h01020304},
            '{1'b0, SZ_WORD, 32'hFFFF_FFFC, 32'h0},
            '{1'b1, SZ_BYTE, 32'h0000_0013, 32'hFFFFFF5A},
            '{1'b0, SZ_WORD, 32'h0000_0010, 32'h0},
            '{1'b0, SZ_HALF, 32'h0000_0020, 32'h0}
        };
        foreach (reqs[i]) begin
            issue(reqs[i].wr, reqs[i].sz, reqs[i].ad, reqs[i].wd);
            repeat (8) @(negedge clk);
        end
        while (expAcc.size() != 0) begin
            e = expAcc.pop_front();
            compared++;
            if (obsAcc.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL store_load access: got none, want cyc %0d addr %h", e.cyc, e.addr);
            end else begin
                o = obsAcc.pop_front();
                if (o.cyc !== e.cyc || o.rw !== e.rw || o.addr !== e.addr || (e.rw && o.data !== e.data)) begin
                    mismatched++;
                    $display("[TB] FAIL store_load access: got cyc %0d rw %b addr %h data %h, want cyc %0d rw %b addr %h data %h",
                             o.cyc, o.rw, o.addr, o.data, e.cyc, e.rw, e.addr, e.data);
                end
            end
        end
        while (expRsp.size() != 0) begin
            er = expRsp.pop_front();
            compared++;
            if (obsRsp.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL store_load rsp: got none, want cyc %0d rdata %h", er.cyc, er.rdata);
            end else begin
                orr = obsRsp.pop_front();
                if (orr.cyc !== er.cyc || orr.err !== er.err || orr.rdata !== er.rdata) begin
                    mismatched++;
                    $display("[TB] FAIL store_load rsp: got cyc %0d err %b rdata %h, want cyc %0d err %b rdata %h",
                             orr.cyc, orr.err, orr.rdata, er.cyc, er.err, er.rdata);
                end
            end
        end
        compared++;
        if (obsAcc.size() != 0 || obsRsp.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL store_load extra: got %0d accesses %0d rsps, want 0 0", obsAcc.size(), obsRsp.size());
        end
        obsAcc.delete();
        obsRsp.delete();
    endtask

    task automatic test_errors();
        req_t reqs [3];
        acc_t o;
        rsp_t er, orr;
        reqs = '{
            '{1'b0, SZ_WORD, 32'h0000_0011, 32'h0},
            '{1'b1, 2'b11,   32'h0000_0050, 32'h99999999},
            '{1'b0, SZ_HALF, 32'h0000_0013, 32'h0}
        };
        foreach (reqs[i]) begin
            issue(reqs[i].wr, reqs[i].sz, reqs[i].ad, reqs[i].wd);
            @(negedge clk);
            compared++;
            if (req_ready !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL error_ready: req %0d got ready %b in cycle 2, want 1", i, req_ready);
            end
            repeat (2) @(negedge clk);
        end
        while (expRsp.size() != 0) begin
            er = expRsp.pop_front();
            compared++;
            if (obsRsp.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL error_rsp: got none, want cyc %0d err 1", er.cyc);
            end else begin
                orr = obsRsp.pop_front();
                if (orr.cyc !== er.cyc || orr.err !== er.err || orr.rdata !== er.rdata) begin
                    mismatched++;
                    $display("[TB] FAIL error_rsp: got cyc %0d err %b rdata %h, want cyc %0d err %b rdata %h",
                             orr.cyc, orr.err, orr.rdata, er.cyc, er.err, er.rdata);
                end
            end
        end
        compared++;
        if (obsAcc.size() != expAcc.size()) begin
            o = obsAcc[0];
            mismatched++;
            $display("[TB] FAIL error_no_access: got %0d accesses (first addr %h), want 0", obsAcc.size(), o.addr);
        end
        compared++;
        if (memArray[8'h50] !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL error_mem: got mem[0x50] %h, want 00", memArray[8'h50]);
        end
        expAcc.delete();
        obsAcc.delete();
        obsRsp.delete();
    endtask

    task automatic test_back_to_back();
        int   base;
        acc_t e, o;
        rsp_t er, orr;
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD;
        req_addr  = 32'h40; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        base = cyc - 1;
        predict(1'b1, SZ_WORD, 32'h40, 32'hCAFEF00D, base);
        req_write = 1'b0; req_size = SZ_BYTE; req_addr = 32'h43; req_wdata = 32'h0;
        predict(1'b0, SZ_BYTE, 32'h43, 32'h0, base + 6);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 5) begin
                compared++;
                if (req_ready !== (k == 6)) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_ready: cycle %0d got %b, want %b", k, req_ready, (k == 6));
                end
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        while (expAcc.size() != 0) begin
            e = expAcc.pop_front();
            compared++;
            if (obsAcc.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL b2b_access: got none, want cyc %0d addr %h", e.cyc, e.addr);
            end else begin
                o = obsAcc.pop_front();
                if (o.cyc !== e.cyc || o.rw !== e.rw || o.addr !== e.addr || (e.rw && o.data !== e.data)) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_access: got cyc %0d rw %b addr %h data %h, want cyc %0d rw %b addr %h data %h",
                             o.cyc, o.rw, o.addr, o.data, e.cyc, e.rw, e.addr, e.data);
                end
            end
        end
        while (expRsp.size() != 0) begin
            er = expRsp.pop_front();
            compared++;
            if (obsRsp.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL b2b_rsp: got none, want cyc %0d rdata %h", er.cyc, er.rdata);
            end else begin
                orr = obsRsp.pop_front();
                if (orr.cyc !== er.cyc || orr.err !== er.err || orr.rdata !== er.rdata) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_rsp: got cyc %0d err %b rdata %h, want cyc %0d err %b rdata %h",
                             orr.cyc, orr.err, orr.rdata, er.cyc, er.err, er.rdata);
                end
            end
        end
        compared++;
        if (obsAcc.size() != 0 || obsRsp.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_extra: got %0d accesses %0d rsps, want 0 0", obsAcc.size(), obsRsp.size());
        end
        obsAcc.delete();
        obsRsp.delete();
    endtask

    task automatic test_reset_abort();
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD;
        req_addr  = 32'h60; req_wdata = 32'h11223344;
        @(negedge clk);
        req_valid = 1'b0;
        compared++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h60) begin
            mismatched++;
            $display("[TB] FAIL abort_first: got en %b addr %h, want 1 00000060", mem_en, mem_addr);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        compared++;
        if (mem_en !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_en_drop: got en %b, want 0", mem_en);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        compared++;
        if (obsAcc.size() != 1 || obsRsp.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL abort_activity: got %0d accesses %0d rsps, want 1 0", obsAcc.size(), obsRsp.size());
        end
        compared++;
        if (memArray[8'h60] !== 8'h11 || memArray[8'h61] !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL abort_mem: got %h %h, want 11 00", memArray[8'h60], memArray[8'h61]);
        end
        compared++;
        if (req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL abort_idle: got ready %b rdata %h, want 1 00000000", req_ready, rsp_rdata);
        end
        obsAcc.delete();
        obsRsp.delete();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Load/store initiator for the byte-wide data memory port. Accepts one load or store request at a time from the MEM stage, checks alignment and issues 1, 2 or 4 sequential byte accesses in big-endian order (byte at `Address` is most significant). For loads it assembles the bytes into a right-aligned, zero-extended word. It returns a one-cycle response pulse and holds `req_ready` low so the pipeline stalls while the request is in progress.

## Interface
Parameters:
- `ADDR_W`, 32: address width on request and memory sides.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: sequencer idle. A request is accepted when `req_valid && req_ready`.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 half-word, 10 word, 11 illegal.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `mem_en` output 1: byte access this cycle.
- `mem_rw` output 1: 1 = write, 0 = read.
- `mem_addr` output ADDR_W: byte address.
- `mem_wdata` output 8: write byte.
- `mem_rdata` input 8: read byte, valid the cycle after a read issue.
- `rsp_valid` output 1: one-cycle completion pulse.
- `rsp_err` output 1: qualifies `rsp_valid`; misaligned or illegal size.
- `rsp_rdata` output 32: load result, held until the next load response.

## Operation
- Reset values: state IDLE, `req_ready`=1, `mem_en`=0, `mem_rw`=0, `mem_addr`=0, `mem_wdata`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, byte counter 0.
- On acceptance, latch write, size, addr and wdata. Byte count N is 1, 2 or 4 for size 00, 01, 10.
- Error check at acceptance:
  - size 11 → error.
  - half-word with `addr[0]`≠0 → error.
  - word with `addr[1:0]`≠0 → error.
  - An error issues no memory access and goes straight to RESP with `rsp_err`=1. `rsp_rdata` is left unchanged.
- States:
  - IDLE → ACCESS on a valid request; IDLE → RESP on an errored request.
  - ACCESS: issue byte k (k=0..N-1) with `mem_addr` = base + k. Store byte k is `wdata[8(N-1-k)+7 : 8(N-1-k)]`.
    - After byte N-1: a store goes to RESP; a load goes to DRAIN.
  - DRAIN (loads only): capture the final byte, then go to RESP.
  - RESP: `rsp_valid`=1 for exactly one cycle, then return to IDLE.
- Load assembly: on each cycle after a read issue, shift left by 8 and OR in `mem_rdata`. The accumulator clears at acceptance, so results are zero-extended. On a load response, `rsp_rdata` takes the accumulator value.
- The response cannot be back-pressured; the consumer must take `rsp_valid` when it pulses.
- `req_valid` is ignored in all states other than IDLE, including RESP. The request fields need not be held after acceptance.
- Address arithmetic is modulo 2^ADDR_W; base + k wraps.
- Reset mid-operation aborts the request: `mem_en` drops immediately (asynchronous) and no response is produced.

## Timing
- Acceptance edge = cycle 0.
- Store of N bytes: `mem_en` high in cycles 1..N, `rsp_valid` in cycle N+1. Word store: 5 cycles to response.
- Load of N bytes: `mem_en` high in cycles 1..N, bytes captured at the ends of cycles 2..N+1, `rsp_valid` in cycle N+2. Word load: 6 cycles to response.
- Error: `rsp_valid` in cycle 1.
- `req_ready` is low from cycle 1 through the RESP cycle and high again the cycle after RESP. Back-to-back requests are therefore spaced N+2 cycles (stores) or N+3 cycles (loads).
- All outputs are registered; none are combinational from inputs.

## Structure
- Shared package `mem_seq_pkg` holds:
  - size codes `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - a state enum `IDLE`, `ACCESS`, `DRAIN`, `RESP`;
  - a function mapping size to byte count.
  - The control unit's load/store decode uses the same size codes.
- One sub-module: `mem_read_assembler`, an 8-bit shift-in, 32-bit accumulator with clear and shift-enable inputs. Everything else (FSM, counter, write-byte select) stays in the top module.

## Test plan
- Word store, addr 0x10, wdata 0xDEADBEEF:
  - writes DE, AD, BE, EF to 0x10..0x13 in cycles 1-4;
  - `rsp_valid` in cycle 5 with `rsp_err`=0.
- Word load from 0x10 after the store above:
  - `rsp_rdata`=0xDEADBEEF with `rsp_valid` in cycle 6.
- Half-word load, addr 0x12: `rsp_rdata`=0x0000BEEF. Byte load, addr 0x11: `rsp_rdata`=0x000000AD.
- Misaligned word load at 0x11, and a size-11 request:
  - no `mem_en` for either;
  - `rsp_valid`+`rsp_err` in cycle 1;
  - `rsp_rdata` unchanged.
- Hold `req_valid` high continuously: the second request is accepted only in the cycle after RESP, and no extra memory accesses appear.
- Assert `reset` in cycle 2 of a word store:
  - `mem_en` drops the same cycle;
  - only 1 byte is written;
  - no `rsp_valid`;
  - `req_ready`=1 after reset releases.
